// File: rtl/dot_scan_controller.sv
// Raster sweep of the dot array for driver_sequencer: each dot gets a row phase
// and a column phase, each one settled for PIPE_LATENCY cycles and then dwelled.
module dot_scan_controller #(
  parameter int MEM_LENGTH         = 48,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int DWELL_WIDTH        = 16,
  parameter int PIPE_LATENCY       = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          continuous,
  input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
  output logic                          row_col_select,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          frame_done,
  output logic [7:0]                    frame_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic [MEM_ADDRESS_LENGTH-1:0] LAST_IDX   = MEM_ADDRESS_LENGTH'(MEM_LENGTH - 1);
  localparam logic [DWELL_WIDTH-1:0]        SETUP_LAST = DWELL_WIDTH'(PIPE_LATENCY - 1);

  // Index of the final DWELL cycle; a programmed dwell of 0 behaves as 1.
  function automatic logic [DWELL_WIDTH-1:0] dwell_last(input logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DWELL_WIDTH'(1);
  endfunction

  state_t                        state_q, state_nx;
  logic [DWELL_WIDTH-1:0]        cnt_q, cnt_nx;
  logic [DWELL_WIDTH-1:0]        dwell_q, dwell_nx;
  logic                          pend_q, pend_nx;
  logic [MEM_ADDRESS_LENGTH-1:0] row_nx, col_nx;
  logic                          phase_nx;
  logic [7:0]                    fcount_nx;
  logic                          busy_nx, sv_nx, fd_nx;
  logic                          last_dot;

  assign last_dot = (row_select == LAST_IDX) && (col_select == LAST_IDX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      dwell_q        <= '0;
      pend_q         <= 1'b0;
      row_select     <= '0;
      col_select     <= '0;
      row_col_select <= 1'b0;
      frame_count    <= '0;
      busy           <= 1'b0;
      sample_valid   <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state_q        <= state_nx;
      cnt_q          <= cnt_nx;
      dwell_q        <= dwell_nx;
      pend_q         <= pend_nx;
      row_select     <= row_nx;
      col_select     <= col_nx;
      row_col_select <= phase_nx;
      frame_count    <= fcount_nx;
      busy           <= busy_nx;
      sample_valid   <= sv_nx;
      frame_done     <= fd_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    dwell_nx  = dwell_q;
    row_nx    = row_select;
    col_nx    = col_select;
    phase_nx  = row_col_select;
    fcount_nx = frame_count;
    // A stop seen on the very edge that ends a dot still halts at that dot.
    pend_nx   = pend_q | ((state_q != IDLE) & stop);
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_nx = SETUP;
          cnt_nx   = '0;
          row_nx   = '0;
          col_nx   = '0;
          phase_nx = 1'b0;
          dwell_nx = dwell_cycles;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_nx = DWELL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + DWELL_WIDTH'(1);
        end
      end
      DWELL: begin
        if (cnt_q != dwell_last(dwell_q)) begin
          cnt_nx = cnt_q + DWELL_WIDTH'(1);
        end else if (!row_col_select) begin
          cnt_nx   = '0;
          phase_nx = 1'b1;
          state_nx = SETUP;
        end else begin
          cnt_nx   = '0;
          phase_nx = 1'b0;
          if (last_dot) fcount_nx = frame_count + 8'd1;
          if (pend_nx || (last_dot && !continuous)) begin
            state_nx = IDLE;
            row_nx   = '0;
            col_nx   = '0;
            pend_nx  = 1'b0;
          end else begin
            state_nx = SETUP;
            if (col_select == LAST_IDX) begin
              col_nx = '0;
              if (last_dot) begin
                row_nx   = '0;
                dwell_nx = dwell_cycles;
              end else begin
                row_nx = row_select + MEM_ADDRESS_LENGTH'(1);
              end
            end else begin
              col_nx = col_select + MEM_ADDRESS_LENGTH'(1);
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    busy_nx = (state_nx != IDLE);
    sv_nx   = (state_nx == DWELL);
    fd_nx   = (state_nx == DWELL) && (cnt_nx == dwell_last(dwell_nx)) && phase_nx &&
              (row_nx == LAST_IDX) && (col_nx == LAST_IDX);
  end

endmodule

// File: tb/tb_dot_scan_controller.sv
// Bench for dot_scan_controller on a 4x4 array: traces are compared against a
// raster-order model built from per-dot phase/settle/dwell timing.
module tb_dot_scan_controller;
  localparam int L  = 4;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int P  = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic [DW-1:0] dwell_cycles = '0;
  logic [AW-1:0] row_select, col_select;
  logic          row_col_select, sample_valid, busy, frame_done;
  logic [7:0]    frame_count;

  dot_scan_controller #(
    .MEM_LENGTH(L), .MEM_ADDRESS_LENGTH(AW), .DWELL_WIDTH(DW), .PIPE_LATENCY(P)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .continuous(continuous), .dwell_cycles(dwell_cycles),
    .row_select(row_select), .col_select(col_select),
    .row_col_select(row_col_select), .sample_valid(sample_valid),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          busy;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic          rcs;
    logic          sv;
    logic          fd;
    logic [7:0]    fc;
  } rec_t;

  rec_t          exp_q[$];
  rec_t          obs_q[$];
  logic [7:0]    fc_exp = '0;
  int            tests = 0;
  int            fails = 0;
  int            stop_at = -1, start_at = -1, cont_clear_at = -1, dwell_chg_at = -1;
  logic [DW-1:0] dwell_new = '0;

  function automatic string fmt(rec_t r);
    return $sformatf("busy=%0b row=%0d col=%0d rcs=%0b sv=%0b fd=%0b fc=%0d",
                     r.busy, r.row, r.col, r.rcs, r.sv, r.fd, r.fc);
  endfunction

  // Reference: ndots dots in raster order, each = two phases of P settle + D dwell.
  task automatic model_frame(input int d_raw, input int ndots);
    int   d;
    rec_t r;
    d = (d_raw == 0) ? 1 : d_raw;
    for (int k = 0; k < ndots; k++)
      for (int ph = 0; ph < 2; ph++)
        for (int t = 0; t < P + d; t++) begin
          r.busy = 1'b1;
          r.row  = AW'(k / L);
          r.col  = AW'(k % L);
          r.rcs  = (ph == 1);
          r.sv   = (t >= P);
          r.fd   = (k == L * L - 1) && (ph == 1) && (t == P + d - 1);
          r.fc   = fc_exp;
          exp_q.push_back(r);
          if (r.fd) fc_exp++;
        end
  endtask

  task automatic model_idle(input int n);
    rec_t r;
    r = '0;
    r.fc = fc_exp;
    for (int i = 0; i < n; i++) exp_q.push_back(r);
  endtask

  task automatic launch(input int d, input logic cont);
    @(negedge clock);
    dwell_cycles = DW'(d);
    continuous   = cont;
    start        = 1'b1;
  endtask

  task automatic capture(input int n);
    rec_t r;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      r.busy = busy; r.row = row_select; r.col = col_select; r.rcs = row_col_select;
      r.sv = sample_valid; r.fd = frame_done; r.fc = frame_count;
      obs_q.push_back(r);
      stop  = (i == stop_at);
      start = (i == start_at);
      if (i == cont_clear_at) continuous = 1'b0;
      if (i == dwell_chg_at) dwell_cycles = dwell_new;
    end
    start = 1'b0;
    stop  = 1'b0;
    stop_at = -1; start_at = -1; cont_clear_at = -1; dwell_chg_at = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++;
    if ({busy, sample_valid, frame_done, row_col_select, row_select, col_select, frame_count} !== '0) begin
      fails++;
      $display("FAIL reset_values got busy=%0b sv=%0b fd=%0b fc=%0d required all zero",
               busy, sample_valid, frame_done, frame_count);
    end
    reset_n = 1'b1;
    fc_exp = '0;
    repeat (3) @(negedge clock);
    tests++;
    if (busy !== 1'b0 || sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_stays_idle got busy=%0b sv=%0b required 0", busy, sample_valid);
    end
  endtask

  task automatic test_single_frame();
    int bad, n_busy, n_fd, fd_idx;
    exp_q.delete();
    model_frame(1, L * L);
    model_idle(3);
    launch(1, 1'b0);
    capture(exp_q.size());
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL single_frame_trace cycle %0d got {%s} expected {%s}", bad, fmt(obs_q[bad]), fmt(exp_q[bad]));
    end
    n_busy = 0; n_fd = 0; fd_idx = -1;
    foreach (obs_q[i]) begin
      if (obs_q[i].busy) n_busy++;
      if (obs_q[i].fd) begin n_fd++; fd_idx = i; end
    end
    tests++;
    if (n_busy != 96) begin
      fails++;
      $display("FAIL single_frame_busy_cycles got %0d required 96", n_busy);
    end
    tests++;
    if (n_fd != 1 || fd_idx != 95) begin
      fails++;
      $display("FAIL single_frame_done got %0d pulses at cycle %0d required 1 at 95", n_fd, fd_idx);
    end
    tests++;
    if (obs_q[obs_q.size() - 1].fc !== 8'd1 || obs_q[obs_q.size() - 1].busy !== 1'b0) begin
      fails++;
      $display("FAIL single_frame_end got fc=%0d busy=%0b required fc=1 busy=0",
               obs_q[obs_q.size() - 1].fc, obs_q[obs_q.size() - 1].busy);
    end
  endtask

  task automatic test_dwell();
    int bad, n_busy;
    for (int d = 0; d < 4; d += (d == 1) ? 2 : 1) begin
      exp_q.delete();
      model_frame(d, L * L);
      model_idle(2);
      launch(d, 1'b0);
      capture(exp_q.size());
      bad = -1;
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL dwell%0d_trace cycle %0d got {%s} expected {%s}", d, bad, fmt(obs_q[bad]), fmt(exp_q[bad]));
      end
      if (d == 3) begin
        n_busy = 0;
        foreach (obs_q[i]) if (obs_q[i].busy) n_busy++;
        tests++;
        if (n_busy != 160) begin
          fails++;
          $display("FAIL dwell3_busy_cycles got %0d required 160", n_busy);
        end
      end
    end
  endtask

  task automatic test_stop();
    int bad, n_fd;
    logic [7:0] fc_before;
    fc_before = fc_exp;
    exp_q.delete();
    model_frame(1, 7);
    model_idle(3);
    stop_at = 37;
    launch(1, 1'b0);
    capture(exp_q.size());
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL stop_trace cycle %0d got {%s} expected {%s}", bad, fmt(obs_q[bad]), fmt(exp_q[bad]));
    end
    n_fd = 0;
    foreach (obs_q[i]) if (obs_q[i].fd) n_fd++;
    tests++;
    if (n_fd != 0 || obs_q[obs_q.size() - 1].fc !== fc_before) begin
      fails++;
      $display("FAIL stop_no_frame got fd=%0d fc=%0d required fd=0 fc=%0d", n_fd, obs_q[obs_q.size() - 1].fc, fc_before);
    end
  endtask

  task automatic test_continuous();
    int bad, n_fd;
    exp_q.delete();
    model_frame(1, L * L);
    model_frame(2, L * L);
    model_frame(2, L * L);
    model_idle(3);
    dwell_chg_at  = 10;
    dwell_new     = 16'd2;
    cont_clear_at = 96 + 128 + 5;
    launch(1, 1'b1);
    capture(exp_q.size());
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL continuous_trace cycle %0d got {%s} expected {%s}", bad, fmt(obs_q[bad]), fmt(exp_q[bad]));
    end
    n_fd = 0;
    foreach (obs_q[i]) if (obs_q[i].fd) n_fd++;
    tests++;
    if (n_fd != 3) begin
      fails++;
      $display("FAIL continuous_frame_done got %0d required 3", n_fd);
    end
  endtask

  task automatic test_wrap();
    int bad, nf;
    bit wrapped;
    nf = 257 - int'(fc_exp);
    exp_q.delete();
    for (int f = 0; f < nf; f++) model_frame(1, L * L);
    model_idle(2);
    cont_clear_at = (nf - 1) * 96 + 5;
    launch(1, 1'b1);
    capture(exp_q.size());
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL wrap_trace cycle %0d got {%s} expected {%s}", bad, fmt(obs_q[bad]), fmt(exp_q[bad]));
    end
    wrapped = 1'b0;
    for (int i = 1; i < obs_q.size(); i++)
      if (obs_q[i - 1].fc == 8'd255 && obs_q[i].fc == 8'd0) wrapped = 1'b1;
    tests++;
    if (!wrapped || obs_q[obs_q.size() - 1].fc !== 8'd1) begin
      fails++;
      $display("FAIL wrap_count got wrapped=%0b final fc=%0d required wrapped=1 fc=1", wrapped, obs_q[obs_q.size() - 1].fc);
    end
  endtask

  task automatic test_ignored();
    int bad;
    exp_q.delete();
    model_frame(2, L * L);
    model_idle(2);
    start_at = 20;
    launch(2, 1'b0);
    capture(exp_q.size());
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL start_while_busy_trace cycle %0d got {%s} expected {%s}", bad, fmt(obs_q[bad]), fmt(exp_q[bad]));
    end
    @(negedge clock);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (busy !== 1'b0 || sample_valid !== 1'b0 || row_select !== '0 || col_select !== '0 || frame_count !== fc_exp) begin
        fails++;
        $display("FAIL start_stop_idle got busy=%0b sv=%0b row=%0d col=%0d fc=%0d required idle fc=%0d",
                 busy, sample_valid, row_select, col_select, frame_count, fc_exp);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    launch(2, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (P) @(negedge clock);
    tests++;
    if (sample_valid !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_in_dwell got sv=%0b required 1", sample_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({busy, sample_valid, frame_done, row_col_select, row_select, col_select, frame_count} !== '0) begin
      fails++;
      $display("FAIL async_reset_zero got busy=%0b sv=%0b row=%0d col=%0d fc=%0d required all zero",
               busy, sample_valid, row_select, col_select, frame_count);
    end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    fc_exp = '0;
    repeat (2) @(negedge clock);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_no_resume got busy=%0b required 0", busy);
    end
    exp_q.delete();
    model_frame(1, L * L);
    model_idle(2);
    launch(1, 1'b0);
    capture(exp_q.size());
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL restart_trace cycle %0d got {%s} expected {%s}", bad, fmt(obs_q[bad]), fmt(exp_q[bad]));
    end
  endtask

  task automatic test_random();
    int   bad, d, de, dl, total, ndots;
    logic cont;
    for (int it = 0; it < 6; it++) begin
      d     = $urandom_range(0, 3);
      de    = (d == 0) ? 1 : d;
      dl    = 2 * (P + de);
      total = L * L * dl;
      if (it == 0) begin
        stop_at = total - 3;
        cont    = 1'b1;
      end else if ($urandom_range(0, 2) != 0) begin
        stop_at = $urandom_range(0, total - 1);
        cont    = 1'($urandom_range(0, 1));
      end else begin
        stop_at = -1;
        cont    = 1'b0;
      end
      ndots    = (stop_at >= 0) ? stop_at / dl + 1 : L * L;
      start_at = $urandom_range(1, ndots * dl - 1);
      exp_q.delete();
      model_frame(d, ndots);
      model_idle(2);
      launch(d, cont);
      capture(exp_q.size());
      bad = -1;
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL random%0d_trace d=%0d cycle %0d got {%s} expected {%s}", it, d, bad, fmt(obs_q[bad]), fmt(exp_q[bad]));
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_dwell();
    test_stop();
    test_continuous();
    test_wrap();
    test_ignored();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
